// File: rtl/dbg_bus_master_pkg.sv
// Shared definitions for the debug bus master: command/reply byte codes and FSM states.
package dbg_bus_master_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;

    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_UNK   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ADDR,
        ST_CMD_DATA,
        ST_REQ,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dbg_bus_master_resp_ser.sv
// Response serializer: loads a 1..4 byte word (right-aligned) and shifts it out MSB first
// over a valid/ready handshake, flagging the final accepted byte.
module dbg_resp_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [1:0]  i_nbytes_m1,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [1:0]  r_left;
    logic        r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            // Left-align so the first byte to send always sits in [31:24].
            r_shift <= i_word << {~i_nbytes_m1, 3'b000};
            r_left  <= i_nbytes_m1;
            r_valid <= 1'b1;
        end else if (r_valid && i_tx_ready) begin
            if (r_left == 2'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_shift <= {r_shift[23:0], 8'h00};
                r_left  <= r_left - 2'd1;
            end
        end
    end

    assign o_tx_data  = r_shift[31:24];
    assign o_tx_valid = r_valid;
    assign o_done     = r_valid && i_tx_ready && (r_left == 2'd0);

endmodule

// File: rtl/dbg_bus_master.sv
// Debug bus initiator: byte-stream R/W commands to single-word bus cycles.
// Optional bus-ack timeout enabled by defining DBG_BUS_TIMEOUT_EN.
module dbg_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic        busy
);
    import dbg_bus_master_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic        r_we;
    logic [21:0] r_addr;
    logic [31:0] r_data;

    logic        w_rx_fire;
    logic        w_load;
    logic [31:0] w_load_word;
    logic [1:0]  w_load_nm1;
    logic        w_done;
    logic        w_timeout;

    assign rx_ready  = !rst && (r_state == ST_IDLE || r_state == ST_CMD_ADDR ||
                                r_state == ST_CMD_DATA);
    assign w_rx_fire = rx_valid && rx_ready;

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_nm1  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        w_next = ST_CMD_ADDR;
                    end else begin
                        w_next      = ST_RESP;
                        w_load      = 1'b1;
                        w_load_word = {24'h0, RSP_UNK};
                    end
                end
            end
            ST_CMD_ADDR: begin
                if (w_rx_fire && r_cnt == 2'd2) w_next = r_we ? ST_CMD_DATA : ST_REQ;
            end
            ST_CMD_DATA: begin
                if (w_rx_fire && r_cnt == 2'd3) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus_gnt) w_next = ST_BUS;
            end
            ST_BUS: begin
                if (bus_ack) begin
                    w_next = ST_RESP;
                    w_load = 1'b1;
                    if (r_we) begin
                        w_load_word = {24'h0, RSP_ACK};
                    end else begin
                        w_load_word = bus_din;
                        w_load_nm1  = 2'd3;
                    end
                end else if (w_timeout) begin
                    w_next      = ST_RESP;
                    w_load      = 1'b1;
                    w_load_word = {24'h0, RSP_TMO};
                end
            end
            ST_RESP: begin
                if (w_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_we  <= (rx_data == CMD_WRITE);
                        r_cnt <= 2'd0;
                    end
                end
                ST_CMD_ADDR: begin
                    if (w_rx_fire) begin
                        // Last address byte drops its two byte-lane bits, leaving the word address.
                        if (r_cnt == 2'd2) begin
                            r_addr <= {r_addr[15:0], rx_data[7:2]};
                            r_cnt  <= 2'd0;
                        end else begin
                            r_addr <= {r_addr[13:0], rx_data};
                            r_cnt  <= r_cnt + 2'd1;
                        end
                    end
                end
                ST_CMD_DATA: begin
                    if (w_rx_fire) begin
                        r_data <= {r_data[23:0], rx_data};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DBG_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_tmo <= '0;
        else if (r_state != ST_BUS) r_tmo <= '0;
        else                        r_tmo <= r_tmo + TMO_W'(1);
    end

    assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    dbg_resp_ser u_resp_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_word      (w_load_word),
        .i_nbytes_m1 (w_load_nm1),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_done      (w_done)
    );

    assign bus_req  = (r_state == ST_REQ) || (r_state == ST_BUS);
    assign bus_stb  = (r_state == ST_BUS);
    assign bus_we   = bus_stb && r_we;
    assign bus_addr = r_addr;
    assign bus_dout = r_data;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master with reply and bus-cycle scoreboards.
// Honours DBG_BUS_TIMEOUT_EN (instantiates with TIMEOUT_CYCLES=16).
module tb_dbg_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_stb;
    logic        bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        bus_ack;
    logic        busy;

    always #5 clk = ~clk;

    dbg_bus_master #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .bus_stb  (bus_stb),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_ack  (bus_ack),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [54:0] bus_q[$];   // {we, word addr, write data}

    bit          ack_en    = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rd_word   = '0;
    int          stb_rises = 0;
    int          stb_len   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus slave model: acks ack_delay cycles after strobe, checks the cycle against bus_q.
    initial begin : responder
        int cnt;
        logic prev;
        logic [54:0] e;
        cnt = 0; prev = 1'b0; bus_ack = 1'b0; bus_din = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus_ack = 1'b0; cnt = 0; prev = 1'b0;
            end else begin
                if (bus_stb && !prev) begin stb_rises++; stb_len = 0; end
                if (bus_stb) stb_len++;
                prev = bus_stb;
                if (bus_ack) begin
                    bus_ack = 1'b0; cnt = 0;
                end else if (bus_stb && ack_en) begin
                    if (cnt == ack_delay) begin
                        if (bus_q.size() == 0) begin
                            check("bus_unexpected_cycle", {63'h0, bus_stb}, 64'h0);
                        end else begin
                            e = bus_q.pop_front();
                            check("bus_we", {63'h0, bus_we}, {63'h0, e[54]});
                            check("bus_addr", {42'h0, bus_addr}, {42'h0, e[53:32]});
                            if (e[54]) check("bus_dout", {32'h0, bus_dout}, {32'h0, e[31:0]});
                        end
                        bus_ack = 1'b1; bus_din = rd_word;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Reply monitor: every accepted tx byte must match the head of exp_q.
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("tx_unexpected_byte", {56'h0, tx_data}, 64'h100);
                else                   check("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 300) begin @(negedge clk); n++; end
        if (!rx_ready) check("rx_ready_wait", {63'h0, rx_ready}, 64'h1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_read(input logic [23:0] a, input logic [31:0] d);
        bus_q.push_back({1'b0, a[23:2], 32'h0});
        rd_word = d;
        exp_q.push_back(d[31:24]); exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);  exp_q.push_back(d[7:0]);
        send_byte(8'h52); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
    endtask

    task automatic send_write(input logic [23:0] a, input logic [31:0] d);
        bus_q.push_back({1'b1, a[23:2], d});
        exp_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_busy"}, {63'h0, busy}, 64'h0);
        check({tag, "_reply_left"}, 64'(exp_q.size()), 64'h0);
        check({tag, "_bus_left"}, 64'(bus_q.size()), 64'h0);
        tick();
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_stb && n < 300) begin @(negedge clk); n++; end
        check("stb_wait", {63'h0, bus_stb}, 64'h1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, {63'h0, rx_ready}, 64'h0);
        check({tag, "_tx_valid"}, {63'h0, tx_valid}, 64'h0);
        check({tag, "_tx_data"},  {56'h0, tx_data},  64'h0);
        check({tag, "_bus_req"},  {63'h0, bus_req},  64'h0);
        check({tag, "_bus_stb"},  {63'h0, bus_stb},  64'h0);
        check({tag, "_bus_we"},   {63'h0, bus_we},   64'h0);
        check({tag, "_busy"},     {63'h0, busy},     64'h0);
    endtask

    initial begin : stimulus
        int r0;
        int n;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; bus_gnt = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        check("reset_bus_addr", {42'h0, bus_addr}, 64'h0);
        check("reset_bus_dout", {32'h0, bus_dout}, 64'h0);
        rst = 1'b0;
        tick();
        check("idle_rx_ready", {63'h0, rx_ready}, 64'h1);

        // Read with a 3-cycle slave wait
        ack_delay = 3;
        send_read(24'hFFE004, 32'hDEADBEEF);
        wait_idle("read");
        check("read_stb_len", 64'(stb_len), 64'd4);
        check("read_stb_rises", 64'(stb_rises), 64'd1);

        // Write acked in the first strobe cycle
        ack_delay = 0;
        send_write(24'h000100, 32'h12345678);
        wait_idle("write");
        check("write_stb_len", 64'(stb_len), 64'd1);

        // Arbitration: grant withheld for 20 cycles
        bus_gnt = 1'b0;
        r0 = stb_rises;
        send_read(24'h000010, 32'hCAFEF00D);
        repeat (20) tick();
        check("arb_bus_req", {63'h0, bus_req}, 64'h1);
        check("arb_bus_stb", {63'h0, bus_stb}, 64'h0);
        check("arb_no_cycle", 64'(stb_rises), 64'(r0));
        bus_gnt = 1'b1;
        wait_idle("arb");

        // Unknown command byte, then a normal read
        r0 = stb_rises;
        exp_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle("unknown");
        check("unknown_no_cycle", 64'(stb_rises), 64'(r0));
        ack_delay = 1;
        send_read(24'h123458, 32'h01020304);
        wait_idle("after_unknown");

        // Back-to-back commands with no idle gap inserted by the bench
        ack_delay = 0;
        send_read(24'hABCDEC, 32'h55AA33CC);
        send_write(24'h00FFFC, 32'h87654321);
        send_byte(8'h00);
        exp_q.push_back(8'h3F);
        wait_idle("b2b");

        // Slave never acks
        ack_en = 1'b0;
`ifdef DBG_BUS_TIMEOUT_EN
        exp_q.push_back(8'h54);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_stb();
        n = 1;
        begin : count_stb
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!bus_stb) disable count_stb;
                n++;
            end
        end
        check("timeout_stb_len", 64'(n), 64'd16);
        wait_idle("timeout");
        ack_en = 1'b1;
`else
        send_read(24'h000020, 32'h0BADF00D);
        wait_stb();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_stb) n++;
        end
        check("noack_stb_held", 64'(n), 64'd40);
        ack_en = 1'b1;
        wait_idle("late_ack");
`endif

        // Reset during the bus cycle
        ack_en = 1'b0;
        send_read(24'h000040, 32'h11111111);
        wait_stb();
        tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_bus");
        exp_q.delete(); bus_q.delete();
        ack_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        ack_delay = 2;
        send_read(24'h000044, 32'h76543210);
        wait_idle("after_rst_bus");

        // Reset during a stalled response
        tx_ready = 1'b0;
        ack_delay = 0;
        send_read(24'h000048, 32'hA1B2C3D4);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 300) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_tx_valid", {63'h0, tx_valid}, 64'h1);
            check("stall_tx_data", {56'h0, tx_data}, 64'hA1);
        end
        tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_resp");
        exp_q.delete(); bus_q.delete();
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        send_read(24'h00004C, 32'h0F1E2D3C);
        wait_idle("after_rst_resp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
